// File: rtl/spi_serf.sv
// spi_serf: mode-0 SPI responder that exchanges WIDTH-bit frames with a monarch.
module spi_serf #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    output logic             tx_busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_rdy,
    input  logic             clr_rx_rdy,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                 state, nxt;
    logic [SYNC_STAGES:0]   ss_q, sclk_q, mosi_q;
    logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic                   done, err, mosi_smpl;
    logic [CW-1:0]          rise_cnt;
    logic [WIDTH-1:0]       shft_reg;

    // Synchronizer chains; the top bit of each is the edge-detect history flop.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ss_q   <= '1;
            sclk_q <= '1;
            mosi_q <= '0;
        end else begin
            ss_q   <= {ss_q[SYNC_STAGES-1:0], SS_n};
            sclk_q <= {sclk_q[SYNC_STAGES-1:0], SCLK};
            mosi_q <= {mosi_q[SYNC_STAGES-1:0], MOSI};
        end

    assign ss_fall   = ~ss_q[SYNC_STAGES-1] & ss_q[SYNC_STAGES];
    assign ss_rise   = ss_q[SYNC_STAGES-1] & ~ss_q[SYNC_STAGES];
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_q[SYNC_STAGES];
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_q[SYNC_STAGES];

    assign MISO    = SS_n ? 1'bz : shft_reg[WIDTH-1];
    assign tx_busy = (state == ACTIVE);

    // State register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    // Next state plus end-of-frame classification (good frame vs malformed).
    always_comb begin
        nxt  = state;
        done = 1'b0;
        err  = 1'b0;
        if (state == IDLE) begin
            nxt = ss_fall ? ACTIVE : IDLE;
        end else if (ss_rise) begin
            nxt  = IDLE;
            done = (rise_cnt == CW'(WIDTH));
            err  = (rise_cnt != CW'(WIDTH));
        end
    end

    // Shift datapath, bit counter and receive handshake.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            shft_reg  <= '0;
            rx_data   <= '0;
            rx_rdy    <= 1'b0;
            frame_err <= 1'b0;
            rise_cnt  <= '0;
            mosi_smpl <= 1'b0;
        end else begin
            frame_err <= err;
            rx_rdy    <= done | (rx_rdy & ~clr_rx_rdy);
            if (done)
                rx_data <= {shft_reg[WIDTH-2:0], mosi_smpl};
            if (state == IDLE) begin
                if (wrt)
                    shft_reg <= tx_data;
                if (ss_fall)
                    rise_cnt <= '0;
            end else begin
                if (sclk_rise) begin
                    mosi_smpl <= mosi_q[SYNC_STAGES];
                    if (rise_cnt != CW'(WIDTH + 1))
                        rise_cnt <= rise_cnt + 1'b1;
                end
                // A fall before the first rise is the monarch's front porch and must not shift.
                if (done || (sclk_fall && !ss_rise && rise_cnt != '0))
                    shft_reg <= {shft_reg[WIDTH-2:0], mosi_smpl};
            end
        end
endmodule

// File: tb/tb_spi_serf.sv
// tb_spi_serf: directed and randomized frame exchanges checked against a word-level model.
module tb_spi_serf;
    localparam int W = 16;
    localparam int S = 2;
    localparam int H = 16;

    logic         clk = 0, rst_n = 0, SS_n = 1, SCLK = 1, MOSI = 0;
    logic         wrt = 0, clr_rx_rdy = 0;
    logic [W-1:0] tx_data = '0;
    logic         MISO, tx_busy, rx_rdy, frame_err;
    logic [W-1:0] rx_data;

    int vectors = 0, errs = 0, err_pulses = 0;

    logic [W-1:0] m_rx = '0, m_resp = '0;
    logic         m_rdy = 0;
    bit           m_known = 0;

    spi_serf #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .wrt(wrt), .tx_busy(tx_busy), .rx_data(rx_data),
        .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Count one per clk that frame_err is high, i.e. per pulse.
    always @(posedge clk) if (frame_err === 1'b1) err_pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] v);
        @(negedge clk) tx_data = v; wrt = 1;
        @(negedge clk) wrt = 0;
        m_resp  = v;
        m_known = 1;
    endtask

    task automatic clr();
        @(negedge clk) clr_rx_rdy = 1;
        @(negedge clk) clr_rx_rdy = 0;
        m_rdy = 0;
    endtask

    task automatic bit_cycle(input logic b, input bit mid_wrt, output logic s);
        SCLK = 0;
        MOSI = b;
        if (mid_wrt) begin
            tx_data = 16'hDEAD; wrt = 1;
            @(negedge clk) wrt = 0;
            repeat (H - 1) @(negedge clk);
        end else repeat (H) @(negedge clk);
        s = MISO;
        SCLK = 1;
        repeat (H) @(negedge clk);
    endtask

    // Monarch: nr SCLK cycles carrying w MSB-first, then SS_n high.
    task automatic frame(input logic [W-1:0] w, input int nr, input bit mid_wrt, input bit clr_at_set,
                         output logic [W-1:0] got, output int lat);
        logic [W-1:0] sh;
        logic         s;
        sh  = w;
        got = '0;
        lat = 99;
        @(negedge clk) SS_n = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < nr; i++) begin
            bit_cycle(sh[W-1], mid_wrt && i == 8, s);
            got = {got[W-2:0], s};
            sh  = {sh[W-2:0], 1'b0};
        end
        SS_n = 1;
        if (clr_at_set) begin
            repeat (S) @(negedge clk);
            clr_rx_rdy = 1;
            @(negedge clk) clr_rx_rdy = 0;
        end else
            for (int k = 1; k <= S + 2; k++) begin
                @(posedge clk);
                #1;
                if (rx_rdy && lat == 99) lat = k;
            end
        repeat (8) @(negedge clk);
        if (nr == W) begin
            m_rx = w; m_rdy = 1; m_resp = w; m_known = 1;
        end else m_known = 0;
    endtask

    task automatic check_state(input string t);
        chk({t, "_rx_data"}, rx_data, m_rx);
        chk({t, "_rx_rdy"}, rx_rdy, m_rdy);
        chk({t, "_tx_busy"}, tx_busy, 0);
    endtask

    initial begin
        logic [W-1:0] got, w;
        logic         s;
        int           lat, e0;
        #1;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_rdy", rx_rdy, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);

        // Basic exchange
        load(16'hA5C3);
        e0 = err_pulses;
        frame(16'h1234, W, 0, 0, got, lat);
        chk("basic_resp", got, 16'hA5C3);
        chk("basic_latency_ok", lat <= S + 2, 1);
        chk("basic_err", err_pulses - e0, 0);
        check_state("basic");

        // Back-to-back frames with echo
        frame(16'hFFFF, W, 0, 0, got, lat);
        chk("b2b1_resp", got, 16'h1234);
        frame(16'h0001, W, 0, 0, got, lat);
        chk("b2b2_resp", got, 16'hFFFF);
        check_state("b2b");

        // Short frame
        e0 = err_pulses;
        frame(16'h5555, 10, 0, 0, got, lat);
        chk("short_err", err_pulses - e0, 1);
        check_state("short");

        // Long frame
        clr();
        e0 = err_pulses;
        frame(16'hF0F0, W + 1, 0, 0, got, lat);
        chk("long_err", err_pulses - e0, 1);
        check_state("long");

        // Handshake: mid-frame wrt ignored, clr coincident with set loses
        load(16'h3C5A);
        clr();
        e0 = err_pulses;
        frame(16'h9876, W, 1, 1, got, lat);
        chk("hs_resp", got, 16'h3C5A);
        chk("hs_err", err_pulses - e0, 0);
        check_state("hs");
        frame(16'h4321, W, 0, 0, got, lat);
        chk("hs_echo", got, 16'h9876);
        check_state("hs_echo");

        // Async reset after 8 bits
        load(16'hC0DE);
        e0 = err_pulses;
        @(negedge clk) SS_n = 0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 8; i++) bit_cycle(1'b1, 0, s);
        #3 rst_n = 0;
        #1;
        chk("arst_rx_data", rx_data, 0);
        chk("arst_rx_rdy", rx_rdy, 0);
        chk("arst_tx_busy", tx_busy, 0);
        chk("arst_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        SS_n  = 1;
        repeat (10) @(negedge clk);
        m_rx = '0; m_rdy = 0; m_known = 0;
        chk("arst_err", err_pulses - e0, 0);
        check_state("arst");
        load(16'h0F1E);
        frame(16'hBEEF, W, 0, 0, got, lat);
        chk("arst_next_resp", got, 16'h0F1E);
        check_state("arst_next");

        // Randomized exchanges against the word-level model
        for (int it = 0; it < 8; it++) begin
            logic [W-1:0] exp_resp;
            bit           known;
            if (!m_known || $urandom_range(0, 1) == 1) load(W'($urandom));
            if ($urandom_range(0, 2) == 0) clr();
            exp_resp = m_resp;
            known    = m_known;
            w        = W'($urandom);
            e0       = err_pulses;
            frame(w, W, 0, 0, got, lat);
            if (known) chk("rand_resp", got, exp_resp);
            chk("rand_err", err_pulses - e0, 0);
            check_state("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/spi_serf.md
Name: spi_serf

Overview:
- SPI responder (serf) for the team's 16-bit SPI link, mode 0 framing.
- Sits on the far end of the monarch:
  - receives SS_n, SCLK and MOSI from the monarch and drives MISO;
  - presents each completed 16-bit command to local logic;
  - shifts out a locally supplied 16-bit response in the same frame.
- All SPI inputs are asynchronous to clk and are synchronized internally.

Parameters:
- WIDTH, 16, frame length in bits; shift register, tx_data and rx_data width.
- SYNC_STAGES, 2, metastability flops on SS_n/SCLK/MOSI before edge detection (minimum 2).

Ports:
- clk  input  1  system clock (rising edge)
- rst_n  input  1  reset is asynchronous and active-low
- SS_n  input  1  serf select from monarch, active low
- SCLK  input  1  SPI clock from monarch, idles high
- MOSI  input  1  SPI data from monarch
- MISO  output  1  SPI data to monarch; shft_reg MSB while SS_n low, 1'bz while SS_n high
- tx_data  input  WIDTH  response word to send in the next frame
- wrt  input  1  load tx_data into the shift register; honoured only in IDLE
- tx_busy  output  1  high in ACTIVE (frame in progress)
- rx_data  output  WIDTH  last correctly framed received word
- rx_rdy  output  1  high when rx_data holds a new word
- clr_rx_rdy  input  1  clears rx_rdy
- frame_err  output  1  one-clk pulse on a malformed frame

Behaviour:
- Synchronizers:
  - SS_n, SCLK and MOSI each pass through SYNC_STAGES flops, then one more flop for edge detect.
  - Reset values: SS_n and SCLK chains to 1, MOSI chain to 0.
  - sclk_rise, sclk_fall, ss_fall and ss_rise are single-clk pulses.
  - Latency from pin change to pulse is SYNC_STAGES+1 clks.
- States: IDLE, ACTIVE.
- IDLE:
  - wrt=1 loads shft_reg<=tx_data.
  - ss_fall: clear rise_cnt to 0, go to ACTIVE.
  - SCLK and MOSI activity is ignored.
- ACTIVE:
  - sclk_rise: mosi_smpl<=synced MOSI; rise_cnt increments, saturating at WIDTH+1.
  - sclk_fall with rise_cnt!=0: shft_reg<={shft_reg[WIDTH-2:0],mosi_smpl}.
  - sclk_fall with rise_cnt==0 (monarch front-porch fall) is ignored, so the MSB stays on MISO until the first sample.
  - wrt is ignored.
- ss_rise in ACTIVE:
  - If rise_cnt==WIDTH: final shift; rx_data<={shft_reg[WIDTH-2:0],mosi_smpl}; shft_reg takes the same value; rx_rdy<=1.
  - Otherwise: frame_err pulses, and rx_data, rx_rdy and shft_reg are unchanged.
  - Either way, go to IDLE.
- Simultaneous events:
  - ss_rise and sclk_fall in the same clk: ss_rise handling wins; only one shift occurs.
  - ss_fall while already ACTIVE cannot occur; no special handling.
- rx_rdy:
  - Set has priority over clr_rx_rdy in the same clk.
  - Overwrite while rx_rdy=1 is allowed: the new word replaces the old one and rx_rdy stays 1.
- MISO after a frame without a new wrt: shft_reg holds the last received word, which is echoed in the next frame.
- Reset values:
  - state=IDLE, shft_reg=0, rx_data=0, rx_rdy=0, frame_err=0, tx_busy=0, rise_cnt=0.
  - Reset mid-frame aborts immediately: no rx_rdy and no frame_err.
  - The monarch's SS_n rise after reset release, with no prior ss_fall, is ignored because state is IDLE.
- Arithmetic: rise_cnt is $clog2(WIDTH+2) bits; no wrap.
- Timing margin: a monarch SCLK half-period of at least 16 clks gives MISO at least 12 clks of setup before the monarch's sample.

Test Plan:
- Basic exchange: wrt with tx_data=16'hA5C3, then monarch sends 16'h1234 → rx_rdy rises within SYNC_STAGES+2 clks of SS_n high; rx_data=16'h1234; monarch receives 16'hA5C3.
- Back-to-back frames: send 16'hFFFF then 16'h0001 with no wrt and no clr_rx_rdy between them → rx_data=16'h0001, rx_rdy stays 1, second response = 16'hFFFF (echo).
- Short frame: SS_n low, 10 SCLK cycles, SS_n high → exactly one frame_err pulse; rx_data and rx_rdy keep their prior values; tx_busy=0 afterwards.
- Long frame: 17 rising edges → frame_err, no rx_rdy.
- Handshake: wrt asserted mid-frame with 16'hDEAD → ignored, response unaffected; clr_rx_rdy on the same clk as the rx_rdy set → rx_rdy=1.
- Async reset: assert rst_n low after 8 bits of a frame → all outputs at reset values immediately; the following SS_n rise produces neither frame_err nor rx_rdy; the next full frame works normally.
